// File: rtl/run_ctrl_pkg.sv
// Shared types and encodings for the run/halt/step controller.
// Encodings are fixed so top-level debug wiring can decode o_state / o_halt_cause.
package run_ctrl_pkg;

    localparam logic [1:0] STATE_INIT_ENC = 2'b00;
    localparam logic [1:0] STATE_RUN_ENC  = 2'b01;
    localparam logic [1:0] STATE_HALT_ENC = 2'b10;
    localparam logic [1:0] STATE_STEP_ENC = 2'b11;

    localparam logic [1:0] CMD_NOP_ENC  = 2'b00;
    localparam logic [1:0] CMD_RUN_ENC  = 2'b01;
    localparam logic [1:0] CMD_HALT_ENC = 2'b10;
    localparam logic [1:0] CMD_STEP_ENC = 2'b11;

    localparam logic [1:0] CAUSE_NONE_ENC = 2'b00;
    localparam logic [1:0] CAUSE_CMD_ENC  = 2'b01;
    localparam logic [1:0] CAUSE_BKPT_ENC = 2'b10;
    localparam logic [1:0] CAUSE_STEP_ENC = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = STATE_INIT_ENC,
        ST_RUN  = STATE_RUN_ENC,
        ST_HALT = STATE_HALT_ENC,
        ST_STEP = STATE_STEP_ENC
    } state_e;

    typedef enum logic [1:0] {
        CMD_NOP  = CMD_NOP_ENC,
        CMD_RUN  = CMD_RUN_ENC,
        CMD_HALT = CMD_HALT_ENC,
        CMD_STEP = CMD_STEP_ENC
    } cmd_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = CAUSE_NONE_ENC,
        CAUSE_CMD  = CAUSE_CMD_ENC,
        CAUSE_BKPT = CAUSE_BKPT_ENC,
        CAUSE_STEP = CAUSE_STEP_ENC
    } cause_e;

endpackage

// File: rtl/run_ctrl.sv
// Run/halt/step controller gating PC update and architectural commits of the core.
// Optional PC breakpoint (comparator, skip flag, cause BKPT) enabled by RUN_CTRL_BKPT_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned INSN_CNT_W = 32,
    parameter int unsigned RST_HOLD   = 4,
    parameter bit          BOOT_HALT  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_vld,
    input  logic [1:0]            i_cmd,
    output logic                  o_cmd_rdy,
    input  logic [31:0]           i_pc,
    input  logic                  i_insn_vld,
    input  logic                  i_bkpt_en,
    input  logic [31:0]           i_bkpt_addr,
    output logic                  o_pc_en,
    output logic                  o_commit_en,
    output logic [1:0]            o_state,
    output logic                  o_halted,
    output logic [1:0]            o_halt_cause,
    output logic [INSN_CNT_W-1:0] o_insn_cnt
);

    localparam int unsigned     HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_e                  state_q, state_d;
    cause_e                  cause_q, cause_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [INSN_CNT_W-1:0]   cnt_q;
    cmd_e                    cmd;
    logic                    cmd_acc;
    logic                    bkpt_match;
    logic                    run_en;
    logic                    cmd_rdy;

    assign cmd     = cmd_e'(i_cmd);
    assign cmd_acc = i_cmd_vld && cmd_rdy;

`ifdef RUN_CTRL_BKPT_EN
    logic skip_q, skip_d;

    // skip masks the breakpoint for the first RUN cycle after a resume only
    always_comb begin
        skip_d = skip_q;
        if (state_q == ST_RUN) begin
            skip_d = 1'b0;
        end else if (state_q == ST_HALT && cmd_acc && cmd == CMD_RUN) begin
            skip_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign bkpt_match = i_bkpt_en && (i_pc == i_bkpt_addr) && (state_q == ST_RUN) && !skip_q;
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{i_bkpt_en, i_bkpt_addr};
    assign bkpt_match  = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_INIT;
            cause_q <= CAUSE_NONE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_INIT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = BOOT_HALT ? ST_HALT : ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // breakpoint takes priority over a same-cycle HALT command
                if (bkpt_match) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BKPT;
                end else if (cmd_acc && cmd == CMD_HALT) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_CMD;
                end
            end
            ST_HALT: begin
                if (cmd_acc && cmd == CMD_RUN) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && cmd == CMD_STEP) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_STEP;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // enables are combinational so suppression lands in the same single-cycle instruction
    always_comb begin
        run_en  = 1'b0;
        cmd_rdy = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                run_en  = !bkpt_match;
                cmd_rdy = 1'b1;
            end
            ST_HALT: cmd_rdy = 1'b1;
            ST_STEP: run_en  = 1'b1;
            default: begin
                run_en  = 1'b0;
                cmd_rdy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (run_en && i_insn_vld) begin
            cnt_q <= cnt_q + INSN_CNT_W'(1);
        end
    end

    assign o_pc_en      = run_en;
    assign o_commit_en  = run_en;
    assign o_cmd_rdy    = cmd_rdy;
    assign o_state      = state_q;
    assign o_halted     = (state_q == ST_HALT);
    assign o_halt_cause = cause_q;
    assign o_insn_cnt   = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: per-cycle behavioural model plus literal checkpoints.
module tb_run_ctrl;

`ifdef RUN_CTRL_BKPT_EN
    localparam bit HAS_BKPT = 1'b1;
`else
    localparam bit HAS_BKPT = 1'b0;
`endif
    localparam int RST_HOLD = 4;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_vld = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic [31:0] i_pc = '0;
    logic        i_insn_vld = 1'b0;
    logic        i_bkpt_en = 1'b0;
    logic [31:0] i_bkpt_addr = '0;
    logic        o_cmd_rdy, o_pc_en, o_commit_en, o_halted;
    logic [1:0]  o_state, o_halt_cause;
    logic [3:0]  o_insn_cnt;

    int n_vec = 0;
    int n_err = 0;

    // model: mode 0 init, 1 run, 2 halted, 3 stepping; cause 0 none, 1 cmd, 2 bkpt, 3 step
    int m_mode = 0, m_cyc = 0, m_cause = 0, m_cnt = 0;
    bit m_skip = 1'b0, last_en = 1'b0;
    logic [31:0] p = '0;

    run_ctrl #(.INSN_CNT_W(4), .RST_HOLD(RST_HOLD), .BOOT_HALT(1'b0)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_cmd_vld(i_cmd_vld), .i_cmd(i_cmd),
        .o_cmd_rdy(o_cmd_rdy), .i_pc(i_pc), .i_insn_vld(i_insn_vld),
        .i_bkpt_en(i_bkpt_en), .i_bkpt_addr(i_bkpt_addr), .o_pc_en(o_pc_en),
        .o_commit_en(o_commit_en), .o_state(o_state), .o_halted(o_halted),
        .o_halt_cause(o_halt_cause), .o_insn_cnt(o_insn_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit exp_match();
        return HAS_BKPT && i_bkpt_en && (i_pc == i_bkpt_addr) && (m_mode == 1) && !m_skip;
    endfunction

    function automatic bit exp_en();
        return (m_mode == 1 && !exp_match()) || (m_mode == 3);
    endfunction

    always @(posedge clk or posedge i_reset) begin
        bit en, mt, acc;
        if (i_reset) begin
            m_mode = 0; m_cyc = 0; m_cause = 0; m_cnt = 0; m_skip = 1'b0; last_en = 1'b0;
        end else begin
            en  = exp_en();
            mt  = exp_match();
            acc = i_cmd_vld && (m_mode == 1 || m_mode == 2);
            last_en = en;
            if (en && i_insn_vld) m_cnt = (m_cnt + 1) % 16;
            case (m_mode)
                0: begin
                    m_cyc++;
                    if (m_cyc >= RST_HOLD) m_mode = 1;
                end
                1: begin
                    m_skip = 1'b0;
                    if (mt) begin
                        m_mode = 2; m_cause = 2;
                    end else if (acc && i_cmd == 2'b10) begin
                        m_mode = 2; m_cause = 1;
                    end
                end
                2: begin
                    if (acc && i_cmd == 2'b01) begin
                        m_mode = 1; m_skip = 1'b1;
                    end else if (acc && i_cmd == 2'b11) begin
                        m_mode = 3;
                    end
                end
                default: begin
                    m_mode = 2; m_cause = 3;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        #2;
        if (!i_reset) begin
            chk("state", 32'(o_state), 32'(m_mode));
            chk("pc_en", 32'(o_pc_en), 32'(exp_en()));
            chk("commit_en", 32'(o_commit_en), 32'(exp_en()));
            chk("cmd_rdy", 32'(o_cmd_rdy), 32'(m_mode == 1 || m_mode == 2));
            chk("halted", 32'(o_halted), 32'(m_mode == 2));
            chk("cause", 32'(o_halt_cause), 32'(m_cause));
            chk("insn_cnt", 32'(o_insn_cnt), 32'(m_cnt));
        end
    end

    task automatic drv(input logic vld, input logic [1:0] cmd, input logic iv);
        i_cmd_vld  = vld;
        i_cmd      = cmd;
        i_insn_vld = iv;
        i_pc       = p;
    endtask

    task automatic fin();
        @(negedge clk);
        if (last_en) p = p + 32'd4;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(o_state), 32'd0);
        chk({tag, "_pc_en"}, 32'(o_pc_en), 32'd0);
        chk({tag, "_commit"}, 32'(o_commit_en), 32'd0);
        chk({tag, "_rdy"}, 32'(o_cmd_rdy), 32'd0);
        chk({tag, "_halted"}, 32'(o_halted), 32'd0);
        chk({tag, "_cause"}, 32'(o_halt_cause), 32'd0);
        chk({tag, "_cnt"}, 32'(o_insn_cnt), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        i_reset = 1'b0;
        p = 32'h30;
        for (int k = 0; k < RST_HOLD; k++) begin
            drv(1'b1, 2'b01, 1'b1);
            fin();
        end
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("boot_state", 32'(o_state), 32'd1);
        chk("boot_pc_en", 32'(o_pc_en), 32'd1);
        fin();
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, (k == 1) ? 2'b01 : 2'b11, 1'b1);
            fin();
        end
        drv(1'b1, 2'b10, 1'b1);
        #2 chk("pre_halt_cnt", 32'(o_insn_cnt), 32'd5);
        fin();
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("halt_halted", 32'(o_halted), 32'd1);
        chk("halt_cause", 32'(o_halt_cause), 32'd1);
        chk("halt_cnt", 32'(o_insn_cnt), 32'd6);
        fin();
        drv(1'b1, 2'b10, 1'b1); fin();
        drv(1'b1, 2'b11, 1'b1); fin();
        drv(1'b1, 2'b01, 1'b1);
        #2 chk("step_state", 32'(o_state), 32'd3);
        chk("step_rdy", 32'(o_cmd_rdy), 32'd0);
        chk("step_pc_en", 32'(o_pc_en), 32'd1);
        fin();
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("step_cause", 32'(o_halt_cause), 32'd3);
        chk("step_cnt", 32'(o_insn_cnt), 32'd7);
        fin();

        i_bkpt_en = 1'b1;
        i_bkpt_addr = 32'h40;
        p = 32'h38;
        drv(1'b1, 2'b01, 1'b1); fin();
        drv(1'b0, 2'b00, 1'b1); fin();
        drv(1'b0, 2'b00, 1'b1); fin();
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("bkpt_pc_en", 32'(o_pc_en), HAS_BKPT ? 32'd0 : 32'd1);
        fin();
        drv(1'b1, 2'b01, 1'b1);
        #2 chk("bkpt_halted", 32'(o_halted), 32'(HAS_BKPT));
        chk("bkpt_cause", 32'(o_halt_cause), HAS_BKPT ? 32'd2 : 32'd3);
        chk("bkpt_cnt", 32'(o_insn_cnt), HAS_BKPT ? 32'd9 : 32'd10);
        fin();
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("resume_state", 32'(o_state), 32'd1);
        chk("resume_pc_en", 32'(o_pc_en), 32'd1);
        fin();
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("resume_cnt", 32'(o_insn_cnt), HAS_BKPT ? 32'd10 : 32'd12);
        chk("resume_pc_en2", 32'(o_pc_en), 32'd1);
        fin();
        i_bkpt_addr = p;
        drv(1'b1, 2'b10, 1'b1);
        #2 chk("race_pc_en", 32'(o_pc_en), HAS_BKPT ? 32'd0 : 32'd1);
        fin();
        i_bkpt_en = 1'b0;
        drv(1'b0, 2'b00, 1'b1);
        #2 chk("race_cause", 32'(o_halt_cause), HAS_BKPT ? 32'd2 : 32'd1);
        chk("race_cnt", 32'(o_insn_cnt), HAS_BKPT ? 32'd11 : 32'd14);
        fin();

        drv(1'b1, 2'b11, 1'b1); fin();
        drv(1'b0, 2'b00, 1'b1);
        #3 i_reset = 1'b1;
        #1 chk_reset_vals("midstep");
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        p = 32'h100;
        for (int k = 0; k < RST_HOLD; k++) begin
            drv(1'b0, 2'b00, 1'b1);
            fin();
        end
        for (int k = 0; k < 20; k++) begin
            drv(1'b0, 2'b00, (k % 7) != 3);
            fin();
        end
        drv(1'b0, 2'b00, 1'b0);
        #2 chk("wrap_cnt", 32'(o_insn_cnt), 32'd1);
        fin();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
